instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Debug-side writer that fills instruction memory before execution.
- Accepts a byte stream from the debug UART receiver and packs each group of 4 bytes into a 32-bit instruction.
- Drives the fetch stage's instruction write port (write-enable, address, data) with one single-cycle write per instruction.
- Stops on a HALT word or when memory capacity is reached, then reports done/error to the debug unit FSM.

Parameters:
- NB, 32, data and address width.
- TAM, 256, instruction memory capacity in 32-bit words.
- HALT_WORD, 32'hFFFFFFFF, instruction value that terminates a load.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_load_start  in  1  one-cycle pulse from debug FSM; begins a load session.
- i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a new byte.
- i_rx_data  in  8  received byte.
- o_instruction_write_enable  out  1  one-cycle write strobe to instruction memory.
- o_instruction_address  out  NB  byte address of the word being written; word-aligned.
- o_instruction_data  out  NB  assembled instruction.
- o_busy  out  1  high from start until done.
- o_load_done  out  1  one-cycle pulse when the session ends.
- o_error  out  1  sticky overflow flag; cleared by the next i_load_start or by reset.
- o_word_count  out  NB  number of words written in the current or last session.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State IDLE.
  - All outputs 0; byte counter 0; address register 0; shift register 0.
  - Reset asserted mid-session abandons the session immediately; no further writes occur.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - i_rx_valid is ignored.
  - i_load_start=1 -> RECV. Same edge: address=0, word_count=0, byte counter=0, o_error=0, o_busy=1.
- RECV, on each i_rx_valid:
  - Shift register becomes {shift[NB-9:0], i_rx_data}. First byte received ends up as bits [31:24] (big-endian).
  - Byte counter increments modulo 4.
  - On the 4th byte, next state is WRITE and the byte counter returns to 0.
  - i_load_start during RECV is ignored.
- WRITE (exactly 1 cycle):
  - o_instruction_write_enable=1.
  - o_instruction_data = assembled word; o_instruction_address = current address.
  - Write latency: data, address and enable are valid together in the cycle after the edge that captured the 4th byte.
  - At the end of the cycle, address += 4 and word_count += 1.
  - A byte arriving with i_rx_valid during WRITE is dropped. The UART byte spacing guarantees this never happens in normal use.
  - Next state:
    - Word == HALT_WORD -> DONE. The HALT word itself is written.
    - Otherwise, if word_count (after increment) == TAM -> DONE with o_error=1.
    - Otherwise -> RECV.
- Boundary on the last slot: if word TAM-1 is HALT_WORD, o_error stays 0.
- DONE (1 cycle):
  - o_load_done=1; o_busy=0 on the following edge.
  - Next state IDLE.
- Registered outputs:
  - o_instruction_address and o_instruction_data are registered. They hold their last value outside WRITE.
  - o_instruction_write_enable is high only in WRITE.
- Address width rule: the address increments by 4 in NB bits. TAM*4 < 2^NB, so wrap-around cannot occur before the overflow stop.
- o_word_count holds its value after DONE until the next i_load_start.

Test Plan:
- Reset mid-RECV:
  - Stimulus: load_start, bytes 8'h20, 8'h01, then i_reset=0.
  - Required: all outputs 0 immediately (asynchronous), state IDLE, no write strobe; a later 4th byte causes no write.
- Normal load of 2 words:
  - Stimulus: load_start; bytes 20 01 00 05, 24 02 00 03, FF FF FF FF.
  - Required writes, in order:
    - (addr 0, 32'h20010005)
    - (addr 4, 32'h24020003)
    - (addr 8, 32'hFFFFFFFF)
  - Then o_load_done pulse, o_word_count=3, o_error=0.
- Write latency and pulse width:
  - Check o_instruction_write_enable is high for exactly one cycle, starting the cycle after the 4th i_rx_valid.
  - Check the address and data in that cycle.
- Overflow:
  - Stimulus: TAM=4, load 4 non-HALT words.
  - Required: 4 writes (addr 0, 4, 8, 12), o_error=1, o_load_done, word_count=4. A 5th byte stream produces no write.
- Ignored inputs:
  - i_rx_valid bytes in IDLE -> no writes, shift register unaffected: the next session's first word is assembled only from its own bytes.
  - i_load_start during RECV -> address not reset.
- Back-to-back sessions:
  - A second load_start after an overflow clears o_error and restarts at addr 0 with word_count=0.

Source files
------------

// File: rtl/instruction_loader.sv
// instruction_loader
//   Debug-side writer that fills instruction memory before execution.
//   Packs a UART byte stream (big-endian, first byte -> [31:24]) into 32-bit
//   words and issues one single-cycle write per word. A session ends on the
//   HALT word (which is itself written) or when TAM words have been written.
//   Hitting capacity without a HALT raises the sticky o_error flag.
//
// Ports
//   i_clk, i_reset                 clock (rising edge), async active-low reset
//   i_load_start                   1-cycle pulse, starts a session from IDLE
//   i_rx_valid, i_rx_data          byte strobe and byte from the UART receiver
//   o_instruction_write_enable     1-cycle write strobe (WRITE state only)
//   o_instruction_address/_data    registered word address / word, held between writes
//   o_busy                         high from start until the session ends
//   o_load_done                    1-cycle pulse while in DONE
//   o_error                        sticky overflow flag, cleared by next start
//   o_word_count                   words written in current/last session
module instruction_loader #(
  parameter int          NB        = 32,
  parameter int          TAM       = 256,
  parameter logic [NB-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_start,
  input  logic          i_rx_valid,
  input  logic [7:0]    i_rx_data,
  output logic          o_instruction_write_enable,
  output logic [NB-1:0] o_instruction_address,
  output logic [NB-1:0] o_instruction_data,
  output logic          o_busy,
  output logic          o_load_done,
  output logic          o_error,
  output logic [NB-1:0] o_word_count
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [NB-1:0] TAM_W  = NB'(TAM);
  localparam logic [NB-1:0] STEP_W = NB'(4);
  localparam logic [NB-1:0] ONE_W  = NB'(1);

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [NB-1:0] addr;
  logic [NB-1:0] shift;
  logic [NB-1:0] shift_nxt;
  logic          last_byte;
  logic          is_halt;
  logic          is_full;

  assign shift_nxt = {shift[NB-9:0], i_rx_data};
  assign last_byte = i_rx_valid && (byte_cnt == 2'd3);
  // The word being written sits in the data register during WRITE.
  assign is_halt   = (o_instruction_data == HALT_WORD);
  assign is_full   = ((o_word_count + ONE_W) == TAM_W);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_load_start) state_nxt = RECV;
      RECV:  if (last_byte)    state_nxt = WRITE;
      WRITE: state_nxt = (is_halt || is_full) ? DONE : RECV;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      byte_cnt                   <= '0;
      addr                       <= '0;
      shift                      <= '0;
      o_instruction_write_enable <= 1'b0;
      o_instruction_address      <= '0;
      o_instruction_data         <= '0;
      o_busy                     <= 1'b0;
      o_load_done                <= 1'b0;
      o_error                    <= 1'b0;
      o_word_count               <= '0;
    end else begin
      o_instruction_write_enable <= 1'b0;
      o_load_done                <= 1'b0;
      case (state)
        IDLE: if (i_load_start) begin
          addr         <= '0;
          o_word_count <= '0;
          byte_cnt     <= '0;
          o_error      <= 1'b0;
          o_busy       <= 1'b1;
        end
        RECV: if (i_rx_valid) begin
          shift    <= shift_nxt;
          byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 on the 4th byte
          // Load the write port on the capturing edge so enable, address
          // and data all appear together in the WRITE cycle.
          if (last_byte) begin
            o_instruction_write_enable <= 1'b1;
            o_instruction_data         <= shift_nxt;
            o_instruction_address      <= addr;
          end
        end
        WRITE: begin
          addr         <= addr + STEP_W;
          o_word_count <= o_word_count + ONE_W;
          if (is_halt) begin
            o_load_done <= 1'b1;
          end else if (is_full) begin
            o_load_done <= 1'b1;
            o_error     <= 1'b1;
          end
        end
        DONE: o_busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;
  localparam int NB  = 32;
  localparam int TAM = 4;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_load_start = 1'b0;
  logic          i_rx_valid = 1'b0;
  logic [7:0]    i_rx_data = 8'h00;
  logic          we;
  logic [NB-1:0] addr, data, cnt;
  logic          busy, done, err;

  int nvec = 0;
  int nerr = 0;

  instruction_loader #(.NB(NB), .TAM(TAM)) dut (
    .i_clk                      (i_clk),
    .i_reset                    (i_reset),
    .i_load_start               (i_load_start),
    .i_rx_valid                 (i_rx_valid),
    .i_rx_data                  (i_rx_data),
    .o_instruction_write_enable (we),
    .o_instruction_address      (addr),
    .o_instruction_data         (data),
    .o_busy                     (busy),
    .o_load_done                (done),
    .o_error                    (err),
    .o_word_count               (cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; valid is high for exactly one cycle.
  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  // After the 4th byte we sit in the WRITE cycle; one cycle later the strobe must be gone.
  task automatic send_word(input string tag, input logic [31:0] w, input logic [31:0] a);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    chk({tag, ".we"},   {31'd0, we}, 32'd1);
    chk({tag, ".addr"}, addr, a);
    chk({tag, ".data"}, data, w);
    @(negedge i_clk);
    chk({tag, ".we_off"}, {31'd0, we}, 32'd0);
  endtask

  task automatic start_load(input string tag);
    i_load_start = 1'b1;
    @(negedge i_clk);
    i_load_start = 1'b0;
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".err"},  {31'd0, err},  32'd0);
    chk({tag, ".cnt"},  cnt, 32'd0);
  endtask

  initial begin
    // Reset state
    #1 i_reset = 1'b0;
    #1;
    chk("rst.we",   {31'd0, we},   32'd0);
    chk("rst.addr", addr,          32'd0);
    chk("rst.data", data,          32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.err",  {31'd0, err},  32'd0);
    chk("rst.cnt",  cnt,           32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);

    // Bytes in IDLE are ignored
    for (int i = 0; i < 4; i++) send_byte(8'hAA);
    chk("idle.we",   {31'd0, we},   32'd0);
    chk("idle.busy", {31'd0, busy}, 32'd0);
    chk("idle.cnt",  cnt,           32'd0);

    // Normal load: 2 words + HALT, with a stray load_start mid-session
    start_load("ld1");
    send_word("ld1.w0", 32'h20010005, 32'd0);
    i_load_start = 1'b1;
    @(negedge i_clk);
    i_load_start = 1'b0;
    send_word("ld1.w1", 32'h24020003, 32'd4);
    send_word("ld1.halt", 32'hFFFFFFFF, 32'd8);
    chk("ld1.done",   {31'd0, done}, 32'd1);
    chk("ld1.err",    {31'd0, err},  32'd0);
    chk("ld1.cnt",    cnt,           32'd3);
    chk("ld1.busy_d", {31'd0, busy}, 32'd1);
    @(negedge i_clk);
    chk("ld1.done_off", {31'd0, done}, 32'd0);
    chk("ld1.busy_off", {31'd0, busy}, 32'd0);
    chk("ld1.cnt_hold", cnt,           32'd3);

    // Reset mid-RECV
    start_load("mid");
    send_byte(8'h20);
    send_byte(8'h01);
    i_reset = 1'b0;
    #1;
    chk("mid.we",   {31'd0, we},   32'd0);
    chk("mid.addr", addr,          32'd0);
    chk("mid.data", data,          32'd0);
    chk("mid.busy", {31'd0, busy}, 32'd0);
    chk("mid.done", {31'd0, done}, 32'd0);
    chk("mid.cnt",  cnt,           32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    send_byte(8'h00);
    send_byte(8'h05);
    chk("mid.nowr",  {31'd0, we},   32'd0);
    @(negedge i_clk);
    chk("mid.nowr2", {31'd0, we},   32'd0);
    chk("mid.idle",  {31'd0, busy}, 32'd0);

    // Overflow: TAM non-HALT words
    start_load("ovf");
    send_word("ovf.w0", 32'h11223344, 32'd0);
    send_word("ovf.w1", 32'h55667788, 32'd4);
    send_word("ovf.w2", 32'h99AABBCC, 32'd8);
    send_word("ovf.w3", 32'hDDEEFF00, 32'd12);
    chk("ovf.done", {31'd0, done}, 32'd1);
    chk("ovf.err",  {31'd0, err},  32'd1);
    chk("ovf.cnt",  cnt,           32'd4);
    @(negedge i_clk);
    chk("ovf.busy_off", {31'd0, busy}, 32'd0);
    chk("ovf.err_hold", {31'd0, err},  32'd1);
    for (int i = 0; i < 4; i++) send_byte(8'h42);
    chk("ovf.nowr",      {31'd0, we}, 32'd0);
    chk("ovf.addr_hold", addr,        32'd12);
    chk("ovf.data_hold", data,        32'hDDEEFF00);
    @(negedge i_clk);
    chk("ovf.nowr2", {31'd0, we}, 32'd0);

    // Back-to-back: clears error, restarts at 0; HALT in the last slot
    start_load("last");
    send_word("last.w0", 32'h01020304, 32'd0);
    send_word("last.w1", 32'h05060708, 32'd4);
    send_word("last.w2", 32'h090A0B0C, 32'd8);
    send_word("last.halt", 32'hFFFFFFFF, 32'd12);
    chk("last.done", {31'd0, done}, 32'd1);
    chk("last.err",  {31'd0, err},  32'd0);
    chk("last.cnt",  cnt,           32'd4);
    @(negedge i_clk);
    chk("last.busy_off", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
